// File: rtl/chipper_eject_inject_sched.sv
// Eject/inject scheduler for the CHIPPER deflection router: golden-first ejection, local injection grant, golden-ID epochs.
// Latency: 1 cycle, so every decision on inputs sampled at an edge is registered at that edge.
// Backpressure: inj_req is held until inj_gnt pulses; starve_flag rises after STARVE_MAX blocked cycles.
module chipper_eject_inject_sched #(
    parameter logic [4:0] NODE_ID    = 5'd0,
    parameter int         EPOCH_LEN  = 16,
    parameter int         STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] nin,
    input  logic [9:0] sin,
    input  logic [9:0] ein,
    input  logic [9:0] win,
    input  logic       inj_req,
    output logic [3:0] eject_sel,
    output logic       inj_gnt,
    output logic [3:0] inj_slot,
    output logic [3:0] golden_id,
    output logic       starve_flag
);
    localparam int EW = (EPOCH_LEN > 2) ? $clog2(EPOCH_LEN) : 1;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [EW-1:0] EPOCH_LAST = EW'(EPOCH_LEN - 1);
    localparam logic [CW-1:0] SMAX       = CW'(STARVE_MAX);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] STARVED = 2'd2;

    logic [9:0]    flit [4];
    logic [3:0]    vld, cand, gold;
    logic [1:0]    rr_ptr, win_idx, rr_idx;
    logic          gold_hit, rr_hit;
    logic [3:0]    eject_nxt, free, free_low;
    logic [EW-1:0] epoch_cnt;
    logic          epoch_wrap;
    logic [1:0]    state, state_nxt;
    logic [CW-1:0] starve_cnt, cnt_nxt;
    logic          gnt_nxt;

    always_comb begin
        flit[0] = nin;
        flit[1] = sin;
        flit[2] = ein;
        flit[3] = win;
        for (int i = 0; i < 4; i++) begin
            vld[i]  = flit[i][9];
            cand[i] = flit[i][9] && (flit[i][4:0] == NODE_ID);
            gold[i] = cand[i] && (flit[i][8:5] == golden_id);
        end
    end

    // Golden scan runs high-to-low so the lowest index is the last (winning) write.
    always_comb begin
        gold_hit = 1'b0;
        rr_hit   = 1'b0;
        win_idx  = 2'd0;
        rr_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (gold[i]) begin
                gold_hit = 1'b1;
                win_idx  = 2'(i);
            end
        end
        if (!gold_hit) begin
            for (int k = 0; k < 4; k++) begin
                rr_idx = rr_ptr + 2'(k);
                if (!rr_hit && cand[rr_idx]) begin
                    rr_hit  = 1'b1;
                    win_idx = rr_idx;
                end
            end
        end
        eject_nxt = (gold_hit || rr_hit) ? (4'b0001 << win_idx) : 4'b0000;
    end

    assign free     = ~vld | eject_nxt;
    assign free_low = free & (~free + 4'd1);

    // Request and grant are evaluated together, so a request seen in IDLE can be granted on the same edge.
    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        gnt_nxt   = 1'b0;
        if (inj_req) begin
            if (|free) begin
                gnt_nxt = 1'b1;
            end else begin
                cnt_nxt   = (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 1'b1;
                state_nxt = (state == STARVED || cnt_nxt == SMAX) ? STARVED : WAIT;
            end
        end
    end

    assign epoch_wrap  = (epoch_cnt == EPOCH_LAST);
    assign starve_flag = (state == STARVED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch_cnt  <= '0;
            golden_id  <= 4'd0;
            rr_ptr     <= 2'd0;
            eject_sel  <= 4'd0;
            inj_gnt    <= 1'b0;
            inj_slot   <= 4'd0;
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            epoch_cnt <= epoch_wrap ? '0 : epoch_cnt + 1'b1;
            if (epoch_wrap) begin
                golden_id <= golden_id + 4'd1;
            end
            if (rr_hit) begin
                rr_ptr <= win_idx + 2'd1;
            end
            eject_sel  <= eject_nxt;
            inj_gnt    <= gnt_nxt;
            inj_slot   <= gnt_nxt ? free_low : 4'd0;
            state      <= state_nxt;
            starve_cnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_chipper_eject_inject_sched.sv
// Bench for chipper_eject_inject_sched: directed scenarios plus random traffic against a behavioural model.
module tb_chipper_eject_inject_sched;
    localparam logic [4:0] NODE = 5'd0;
    localparam int EL = 16;
    localparam int SM = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] nin, sin, ein, win;
    logic       inj_req;
    logic [3:0] eject_sel, inj_slot, golden_id;
    logic       inj_gnt, starve_flag;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;

    int m_golden, m_epoch, m_rr, m_cnt;
    logic [3:0] e_eject, e_slot, e_golden;
    logic e_gnt, e_starve;

    chipper_eject_inject_sched #(.NODE_ID(NODE), .EPOCH_LEN(EL), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .nin(nin), .sin(sin), .ein(ein), .win(win),
        .inj_req(inj_req), .eject_sel(eject_sel), .inj_gnt(inj_gnt), .inj_slot(inj_slot),
        .golden_id(golden_id), .starve_flag(starve_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mk(bit v, int pid, int dst);
        logic [3:0] p;
        logic [4:0] d;
        p = 4'(pid);
        d = 5'(dst);
        return {v, p, d};
    endfunction

    task automatic model_reset();
        m_golden = 0; m_epoch = 0; m_rr = 0; m_cnt = 0; cyc = 0;
        e_eject = 0; e_slot = 0; e_golden = 0; e_gnt = 0; e_starve = 0;
    endtask

    // Predict the outcome of the coming edge from the rules, then clock and settle.
    task automatic step();
        logic [9:0] f [4];
        int w, fs;
        bit cand;
        f[0] = nin; f[1] = sin; f[2] = ein; f[3] = win;
        w = -1;
        for (int i = 0; i < 4; i++)
            if (w < 0 && f[i][9] && f[i][4:0] == NODE && int'(f[i][8:5]) == m_golden) w = i;
        if (w < 0) begin
            for (int k = 0; k < 4; k++) begin
                int idx = (m_rr + k) % 4;
                cand = f[idx][9] && f[idx][4:0] == NODE;
                if (w < 0 && cand) w = idx;
            end
            if (w >= 0) m_rr = (w + 1) % 4;
        end
        e_eject = (w >= 0) ? 4'(1 << w) : 4'd0;
        fs = -1;
        for (int i = 0; i < 4; i++)
            if (fs < 0 && (!f[i][9] || i == w)) fs = i;
        e_gnt = 0; e_slot = 0; e_starve = 0;
        if (!inj_req) m_cnt = 0;
        else if (fs >= 0) begin
            e_gnt = 1; e_slot = 4'(1 << fs); m_cnt = 0;
        end else begin
            if (m_cnt < SM) m_cnt++;
            e_starve = (m_cnt == SM);
        end
        if (m_epoch == EL - 1) begin
            m_epoch = 0; m_golden = (m_golden + 1) % 16;
        end else m_epoch++;
        e_golden = 4'(m_golden);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_flits(logic [9:0] n, logic [9:0] s, logic [9:0] e, logic [9:0] w);
        nin = n; sin = s; ein = e; win = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inj_req = 1'b1;
        set_flits(mk(1, 0, 0), mk(1, 0, 0), mk(1, 3, 0), mk(1, 0, 7));
        #2;
        n_chk++;
        if ({eject_sel, inj_gnt, inj_slot, golden_id, starve_flag} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %b required 0", {eject_sel, inj_gnt, inj_slot, golden_id, starve_flag});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(); step();
        n_chk++;
        if (eject_sel !== 4'b0001 || inj_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preop: eject=%b gnt=%b required 0001/1", eject_sel, inj_gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({eject_sel, inj_gnt, inj_slot, golden_id, starve_flag} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_midop: got %b required 0", {eject_sel, inj_gnt, inj_slot, golden_id, starve_flag});
        end
        inj_req = 1'b0;
        set_flits(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        n_chk++;
        if (golden_id !== 4'd0 || eject_sel !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: golden=%0d eject=%b required 0/0000", golden_id, eject_sel);
        end
    endtask

    task automatic test_golden();
        set_flits(10'b1_0011_00001, 0, 10'b1_0000_00000, 0);
        step();
        n_chk++;
        if (eject_sel !== 4'b0100 || eject_sel !== e_eject) begin
            n_fail++;
            $display("FAIL golden_win: eject=%b required 0100 (model %b)", eject_sel, e_eject);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0010;
        set_flits(0, mk(1, 5, 0), 0, mk(1, 5, 0));
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (eject_sel !== exp_seq[i] || eject_sel !== e_eject) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: eject=%b required %b", i, eject_sel, exp_seq[i]);
            end
        end
    endtask

    task automatic test_inject();
        set_flits(mk(1, 2, 1), 0, 0, 0);
        inj_req = 1'b1;
        step();
        n_chk++;
        if (inj_gnt !== 1'b1 || inj_slot !== 4'b0010 || e_slot !== 4'b0010) begin
            n_fail++;
            $display("FAIL inject_grant: gnt=%b slot=%b required 1/0010", inj_gnt, inj_slot);
        end
        inj_req = 1'b0;
        step();
        n_chk++;
        if (inj_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL inject_pulse: gnt=%b required 0", inj_gnt);
        end
    endtask

    task automatic test_starve();
        set_flits(mk(1, 1, 3), mk(1, 1, 3), mk(1, 1, 3), mk(1, 1, 3));
        inj_req = 1'b1;
        for (int i = 0; i < SM; i++) begin
            step();
            n_chk++;
            if (starve_flag !== (i == SM - 1) || inj_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL starve[%0d]: flag=%b gnt=%b required %b/0", i, starve_flag, inj_gnt, i == SM - 1);
            end
        end
        win = 10'd0;
        step();
        n_chk++;
        if (inj_gnt !== 1'b1 || inj_slot !== 4'b1000 || starve_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_release: gnt=%b slot=%b flag=%b required 1/1000/0", inj_gnt, inj_slot, starve_flag);
        end
        inj_req = 1'b0;
        step();
    endtask

    task automatic test_full_eject();
        set_flits(mk(1, 1, 3), mk(1, 9, 0), mk(1, 1, 3), mk(1, 1, 3));
        inj_req = 1'b1;
        step();
        n_chk++;
        if (eject_sel !== 4'b0010 || inj_gnt !== 1'b1 || inj_slot !== 4'b0010) begin
            n_fail++;
            $display("FAIL full_eject: eject=%b gnt=%b slot=%b required 0010/1/0010", eject_sel, inj_gnt, inj_slot);
        end
        inj_req = 1'b0;
        set_flits(0, 0, 0, 0);
        step();
    endtask

    task automatic test_epoch();
        while (cyc < 256) begin
            step();
            n_chk++;
            if (golden_id !== 4'((cyc / EL) % 16)) begin
                n_fail++;
                $display("FAIL epoch@%0d: golden=%0d required %0d", cyc, golden_id, (cyc / EL) % 16);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] f [4];
        int pv, pd;
        for (int c = 0; c < 600; c++) begin
            pv = ((c / 100) % 2 == 1) ? 100 : 70;
            pd = ((c / 100) % 2 == 1) ? 5 : 50;
            for (int i = 0; i < 4; i++)
                f[i] = mk($urandom_range(99, 0) < pv,
                          ($urandom_range(1, 0) == 1) ? m_golden : int'($urandom_range(15, 0)),
                          ($urandom_range(99, 0) < pd) ? 0 : int'($urandom_range(31, 1)));
            set_flits(f[0], f[1], f[2], f[3]);
            if (!inj_req) inj_req = ($urandom_range(99, 0) < 30);
            else if (e_gnt || $urandom_range(99, 0) < 3) inj_req = 1'b0;
            step();
            n_chk++;
            if ({eject_sel, inj_gnt, inj_gnt ? inj_slot : 4'd0, golden_id, starve_flag} !==
                {e_eject, e_gnt, e_slot, e_golden, e_starve}) begin
                n_fail++;
                $display("FAIL random@%0d: got ej=%b g=%b s=%b gid=%0d sf=%b required ej=%b g=%b s=%b gid=%0d sf=%b",
                         c, eject_sel, inj_gnt, inj_slot, golden_id, starve_flag,
                         e_eject, e_gnt, e_slot, e_golden, e_starve);
            end
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_round_robin();
        test_inject();
        test_starve();
        test_full_eject();
        test_epoch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
